// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: freeze, flush and a valid-qualified control path.
// Optional perf counters under `define ID_EX_PERF_CNT_EN.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic              id_imm,
  input  logic [11:0]       id_shift_operand,
  input  logic [23:0]       id_signed_imm_24,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [3:0]        id_exe_cmd,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_wb_en,
  input  logic              id_b,
  input  logic              id_s,
  input  logic              id_carry,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic              ex_imm,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic [REG_AW-1:0] ex_dest,
  output logic [REG_AW-1:0] ex_src1,
  output logic [REG_AW-1:0] ex_src2,
  output logic [3:0]        ex_exe_cmd,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_wb_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic              ex_carry
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]       perf_bubbles,
  output logic [15:0]       perf_freezes,
  output logic [15:0]       perf_insts
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rn;
    logic [DATA_W-1:0] rm;
    logic              imm;
    logic [11:0]       sh;
    logic [23:0]       off;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [3:0]        cmd;
    logic              mr;
    logic              mw;
    logic              wb;
    logic              b;
    logic              s;
    logic              c;
  } slot_t;

  slot_t r_ex;
  slot_t w_ld;
  slot_t w_nxt;
  logic  w_load;

  assign w_load = !flush && !freeze;

  // Incoming slot; bubbles keep data but drop every control bit.
  always_comb begin
    w_ld.valid = id_valid;
    w_ld.pc    = id_pc;
    w_ld.rn    = id_val_rn;
    w_ld.rm    = id_val_rm;
    w_ld.imm   = id_imm;
    w_ld.sh    = id_shift_operand;
    w_ld.off   = id_signed_imm_24;
    w_ld.dest  = id_dest;
    w_ld.src1  = id_src1;
    w_ld.src2  = id_src2;
    w_ld.cmd   = id_valid ? id_exe_cmd : 4'd0;
    w_ld.mr    = id_valid & id_mem_read;
    w_ld.mw    = id_valid & id_mem_write;
    w_ld.wb    = id_valid & id_wb_en;
    w_ld.b     = id_valid & id_b;
    w_ld.s     = id_valid & id_s;
    w_ld.c     = id_carry;
  end

  // Flush beats freeze: a branch kill must not be held back.
  always_comb begin
    w_nxt = r_ex;
    priority case (1'b1)
      flush:   w_nxt = '0;
      freeze:  w_nxt = r_ex;
      default: w_nxt = w_ld;
    endcase
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ex <= '0;
    else        r_ex <= w_nxt;
  end

  assign ex_valid         = r_ex.valid;
  assign ex_pc            = r_ex.pc;
  assign ex_val_rn        = r_ex.rn;
  assign ex_val_rm        = r_ex.rm;
  assign ex_imm           = r_ex.imm;
  assign ex_shift_operand = r_ex.sh;
  assign ex_signed_imm_24 = r_ex.off;
  assign ex_dest          = r_ex.dest;
  assign ex_src1          = r_ex.src1;
  assign ex_src2          = r_ex.src2;
  assign ex_exe_cmd       = r_ex.cmd;
  assign ex_mem_read      = r_ex.mr;
  assign ex_mem_write     = r_ex.mw;
  assign ex_wb_en         = r_ex.wb;
  assign ex_b             = r_ex.b;
  assign ex_s             = r_ex.s;
  assign ex_carry         = r_ex.c;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] r_bub;
  logic [15:0] r_frz;
  logic [15:0] r_ins;
  logic        w_bub;
  logic        w_frz;
  logic        w_ins;

  assign w_bub = flush || (w_load && !id_valid);
  assign w_frz = freeze && !flush;
  assign w_ins = w_load && id_valid;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bub <= '0;
      r_frz <= '0;
      r_ins <= '0;
    end else begin
      if (w_bub && r_bub != 16'hFFFF) r_bub <= r_bub + 16'd1;
      if (w_frz && r_frz != 16'hFFFF) r_frz <= r_frz + 16'd1;
      if (w_ins && r_ins != 16'hFFFF) r_ins <= r_ins + 16'd1;
    end
  end

  assign perf_bubbles = r_bub;
  assign perf_freezes = r_frz;
  assign perf_insts   = r_ins;
`endif

endmodule
